line_point_counter: RTL

LINE_POINT_COUNTER -- requirements
Module: line_point_counter

---
 rtl/line_point_counter.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/line_point_counter.sv
// Scans a table of (x,y) points and counts those whose SLOPE*x + y (mod 2^W) hits TARGET.
// Define LPC_TOLERANCE_EN to accept |v - TARGET| <= TOL instead of exact equality.
module line_point_counter #(
    parameter int unsigned W      = 8,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned SLOPE  = 3,
    parameter int unsigned TARGET = 2,
    parameter int unsigned TOL    = 1,
    localparam int unsigned AW    = $clog2(2 * DEPTH),
    localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          START,
    input  logic          WR_EN,
    input  logic [AW-1:0] WR_ADDR,
    input  logic [W-1:0]  WR_DATA,
    output logic [CW-1:0] PUNTI_RETTA,
    output logic          BUSY,
    output logic          DONE
);

    localparam int unsigned IW = $clog2(DEPTH);
    localparam logic [W-1:0]  SLOPE_W  = W'(SLOPE);
    localparam logic [W-1:0]  TARGET_W = W'(TARGET);
    localparam logic [IW-1:0] LAST_I   = IW'(DEPTH - 1);
    localparam logic [AW:0]   NWORDS   = (AW + 1)'(2 * DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_X,
        S_LOAD_Y,
        S_CALC,
        S_ACCUM,
        S_FINISH
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    tbl_q [2*DEPTH];
    logic [W-1:0]    tbl_d [2*DEPTH];
    logic [CW-1:0]   count_q, count_d;
    logic [IW-1:0]   i_q, i_d;
    logic [W-1:0]    x_q, x_d;
    logic [W-1:0]    y_q, y_d;
    logic [W-1:0]    v_q, v_d;
    logic [CW-1:0]   punti_q, punti_d;
    logic            done_q, done_d;
    logic            match;

`ifdef LPC_TOLERANCE_EN
    localparam logic [W:0] TOL_W = (W + 1)'(TOL);
    logic signed [W:0] diff;
    logic        [W:0] mag;

    // W+1-bit signed difference so v below TARGET never wraps to a large value
    always_comb begin
        diff  = $signed({1'b0, v_q}) - $signed({1'b0, TARGET_W});
        mag   = diff[W] ? W'(0) - diff : diff;
        match = (mag <= TOL_W);
    end
`else
    logic unused_tol;
    assign unused_tol = ^((W + 1)'(TOL));

    always_comb begin
        match = (v_q == TARGET_W);
    end
`endif

    always_comb begin
        state_d = state_q;
        tbl_d   = tbl_q;
        count_d = count_q;
        i_d     = i_q;
        x_d     = x_q;
        y_d     = y_q;
        v_d     = v_q;
        punti_d = punti_q;
        done_d  = 1'b0;

        // Writes are accepted only in IDLE, including the cycle START is taken
        if (WR_EN && (state_q == S_IDLE) && ({1'b0, WR_ADDR} < NWORDS)) begin
            tbl_d[WR_ADDR] = WR_DATA;
        end

        case (state_q)
            S_IDLE: begin
                if (START) begin
                    count_d = '0;
                    i_d     = '0;
                    state_d = S_LOAD_X;
                end
            end
            S_LOAD_X: begin
                x_d     = tbl_q[{i_q, 1'b0}];
                state_d = S_LOAD_Y;
            end
            S_LOAD_Y: begin
                y_d     = tbl_q[{i_q, 1'b1}];
                state_d = S_CALC;
            end
            S_CALC: begin
                v_d     = SLOPE_W * x_q + y_q;
                state_d = S_ACCUM;
            end
            S_ACCUM: begin
                if (match) begin
                    count_d = count_q + CW'(1);
                end
                if (i_q != LAST_I) begin
                    i_d     = i_q + IW'(1);
                    state_d = S_LOAD_X;
                end else begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                if (!START) begin
                    punti_d = count_q;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            for (int unsigned k = 0; k < 2 * DEPTH; k++) begin
                tbl_q[k] <= '0;
            end
            count_q <= '0;
            i_q     <= '0;
            x_q     <= '0;
            y_q     <= '0;
            v_q     <= '0;
            punti_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tbl_q   <= tbl_d;
            count_q <= count_d;
            i_q     <= i_d;
            x_q     <= x_d;
            y_q     <= y_d;
            v_q     <= v_d;
            punti_q <= punti_d;
            done_q  <= done_d;
        end
    end

    assign PUNTI_RETTA = punti_q;
    assign DONE        = done_q;
    assign BUSY        = (state_q != S_IDLE);

endmodule
